// File: rtl/ranc_grid_edge_injector.sv
// West-edge packet injector for the RANC core grid.
// One valid/ready packet stream is steered by its signed dy field into one of NUM_ROWS
// show-ahead FIFOs. Each packet is written with dy made relative to the row it lands in.
// Each row is exposed to its core as empty/ren/packet signals.
// Optional: define RANC_INJECTOR_STATS_EN to add row_inject_count, a saturating 16-bit
// count of FIFO writes for each row.
module ranc_grid_edge_injector #(
  parameter int NUM_ROWS     = 2,
  parameter int DX_MSB       = 29,
  parameter int DX_LSB       = 21,
  parameter int DY_MSB       = 20,
  parameter int DY_LSB       = 12,
  parameter int FIFO_DEPTH   = 4,
  parameter int PACKET_WIDTH = 30
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PACKET_WIDTH-1:0]          packet_in,
  input  logic [NUM_ROWS-1:0]              ren_in,
  output logic [NUM_ROWS-1:0]              empty_out,
  output logic [NUM_ROWS*PACKET_WIDTH-1:0] packet_out,
  output logic                             drop_error,
  output logic                             underflow_error
`ifdef RANC_INJECTOR_STATS_EN
  ,
  output logic [NUM_ROWS*16-1:0]           row_inject_count
`endif
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int DyW  = DY_MSB - DY_LSB + 1;
  localparam int RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [DyW-1:0]  LastRowDy = DyW'(NUM_ROWS - 1);
  localparam logic [RowW-1:0] LastRow   = RowW'(NUM_ROWS - 1);

  // Stage register
  logic                    stage_valid_q;
  logic [PACKET_WIDTH-1:0] stage_pkt_q;

  // Per-row FIFO state
  logic [PACKET_WIDTH-1:0] mem_q    [NUM_ROWS][FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q [NUM_ROWS];
  logic [PtrW-1:0]         rd_ptr_q [NUM_ROWS];
  logic [CntW-1:0]         count_q  [NUM_ROWS];

  logic drop_error_q;
  logic underflow_q;

  // Routing of the staged packet
  logic [DyW-1:0]          stage_dy;
  logic [DyW-1:0]          new_dy;
  logic [RowW-1:0]         tgt;
  logic                    drop;
  logic                    tgt_space;
  logic                    stage_adv;
  logic                    wr_en;
  logic [PACKET_WIDTH-1:0] wr_pkt;
  logic [NUM_ROWS-1:0]     push_vec;
  logic [NUM_ROWS-1:0]     pop_vec;
  logic                    accept;

  // Decode the staged packet's dy into a target row and a row-relative dy
  always_comb begin
    stage_dy = stage_pkt_q[DY_MSB:DY_LSB];
    drop     = stage_dy[DyW-1];
    tgt      = LastRow;
    new_dy   = stage_dy - LastRowDy;
    // Non-negative dy inside the grid selects that row exactly; beyond the last row the
    // packet enters the bottom row and keeps travelling the remaining distance.
    if (stage_dy <= LastRowDy) begin
      tgt    = stage_dy[RowW-1:0];
      new_dy = '0;
    end
    wr_pkt                  = stage_pkt_q;
    wr_pkt[DX_MSB:DX_LSB]   = stage_pkt_q[DX_MSB:DX_LSB];
    wr_pkt[DY_MSB:DY_LSB]   = new_dy;
  end

  // Handshake: the stage frees when its packet is dropped or its row has room pre-edge
  always_comb begin
    tgt_space = count_q[tgt] < DepthCnt;
    stage_adv = stage_valid_q & (drop | tgt_space);
    wr_en     = stage_adv & ~drop;
    in_ready  = ~stage_valid_q | stage_adv;
    accept    = in_valid & in_ready;
  end

  // Per-row push/pop decode and row-facing outputs
  always_comb begin
    push_vec   = '0;
    pop_vec    = '0;
    empty_out  = '0;
    packet_out = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      push_vec[r]  = wr_en & (tgt == RowW'(r));
      empty_out[r] = (count_q[r] == '0);
      pop_vec[r]   = ren_in[r] & ~empty_out[r];
      if (!empty_out[r]) begin
        packet_out[r*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[r][rd_ptr_q[r]];
      end
    end
  end

  // Stage register and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_pkt_q   <= '0;
      drop_error_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (accept) begin
        stage_valid_q <= 1'b1;
        stage_pkt_q   <= packet_in;
      end else if (stage_adv) begin
        stage_valid_q <= 1'b0;
      end
      drop_error_q <= stage_adv & drop;
      if (|(ren_in & empty_out)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        count_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (push_vec[r]) begin
          wr_ptr_q[r] <= wr_ptr_q[r] + PtrW'(1);
        end
        if (pop_vec[r]) begin
          rd_ptr_q[r] <= rd_ptr_q[r] + PtrW'(1);
        end
        if (push_vec[r] && !pop_vec[r]) begin
          count_q[r] <= count_q[r] + CntW'(1);
        end else if (pop_vec[r] && !push_vec[r]) begin
          count_q[r] <= count_q[r] - CntW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are masked by empty_out, so no reset is needed
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (push_vec[r]) begin
        mem_q[r][wr_ptr_q[r]] <= wr_pkt;
      end
    end
  end

  assign drop_error      = drop_error_q;
  assign underflow_error = underflow_q;

`ifdef RANC_INJECTOR_STATS_EN
  logic [NUM_ROWS*16-1:0] stat_q;

  // Saturating per-row FIFO write counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (push_vec[r] && (stat_q[r*16 +: 16] != 16'hFFFF)) begin
          stat_q[r*16 +: 16] <= stat_q[r*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign row_inject_count = stat_q;
`endif

endmodule

// File: tb/tb_ranc_grid_edge_injector.sv
// Self-checking bench for ranc_grid_edge_injector (default parameters, NUM_ROWS=2).
// Directed steps plus randomized traffic checked against per-row queue model.
// Define RANC_INJECTOR_STATS_EN to also exercise the saturating write counters.
module tb_ranc_grid_edge_injector;

  localparam int NR = 2;
  localparam int PW = 30;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  packet_in;
  logic [NR-1:0]  ren_in;
  logic [NR-1:0]  empty_out;
  logic [NR*PW-1:0] packet_out;
  logic           drop_error;
  logic           underflow_error;
`ifdef RANC_INJECTOR_STATS_EN
  logic [NR*16-1:0] row_inject_count;
`endif

  ranc_grid_edge_injector dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .packet_in       (packet_in),
    .ren_in          (ren_in),
    .empty_out       (empty_out),
    .packet_out      (packet_out),
    .drop_error      (drop_error),
    .underflow_error (underflow_error)
`ifdef RANC_INJECTOR_STATS_EN
    ,
    .row_inject_count(row_inject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int drops_exp  = 0;
  int drops_seen = 0;
  logic [PW-1:0] mq0[$];
  logic [PW-1:0] mq1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference routing rule: row = -1 means the packet is dropped
  function automatic void route(input logic [PW-1:0] p, output int row, output logic [PW-1:0] q);
    int dy;
    int nd;
    dy = int'($signed(p[20:12]));
    q  = p;
    if (dy < 0) begin
      row = -1;
      nd  = dy;
    end else if (dy < NR) begin
      row = dy;
      nd  = 0;
    end else begin
      row = NR - 1;
      nd  = dy - (NR - 1);
    end
    q[20:12] = nd[8:0];
  endfunction

  function automatic logic [PW-1:0] rand_pkt();
    logic [PW-1:0] p;
    int sel;
    p   = PW'($urandom);
    sel = $urandom_range(0, 9);
    if (sel == 0)      p[20:12] = 9'h100 | 9'($urandom_range(0, 255));
    else if (sel < 6)  p[20:12] = 9'($urandom_range(0, 1));
    else               p[20:12] = 9'($urandom_range(2, 255));
    return p;
  endfunction

  // One clock: called at a negedge with inputs already driven
  task automatic tick();
    logic [NR-1:0] popv;
    logic          acc;
    logic [PW-1:0] q;
    logic [PW-1:0] exp;
    int            row;
    int            sz;
    #1;
    acc  = in_valid & in_ready;
    popv = ren_in & ~empty_out;
    for (int r = 0; r < NR; r++) begin
      if (popv[r]) begin
        sz = (r == 0) ? mq0.size() : mq1.size();
        chk("sb_pop_avail", 64'(sz != 0), 64'(popv[r]));
        if (sz != 0) begin
          exp = (r == 0) ? mq0.pop_front() : mq1.pop_front();
          chk("sb_pop_data", 64'(packet_out[r*PW +: PW]), 64'(exp));
        end
      end
    end
    if (acc) begin
      route(packet_in, row, q);
      if (row < 0)       drops_exp++;
      else if (row == 0) mq0.push_back(q);
      else               mq1.push_back(q);
    end
    @(posedge clk);
    @(negedge clk);
    if (drop_error) drops_seen++;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    ren_in   = '0;
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    ren_in    = '0;
    packet_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_empty", 64'(empty_out), 64'(2'b11));
    chk("rst_packet_out", 64'(packet_out), 64'(0));
    chk("rst_drop", 64'(drop_error), 64'(0));
    chk("rst_underflow", 64'(underflow_error), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Steering: dy=0, dy=1, dy=5
    in_valid = 1'b1;
    packet_in = {9'h015, 9'd0, 12'hABC};
    tick();
    chk("steer_empty_after_accept", 64'(empty_out), 64'(2'b11));
    packet_in = {9'h1F3, 9'd1, 12'h123};
    tick();
    chk("steer_row0_filled", 64'(empty_out), 64'(2'b10));
    packet_in = {9'h007, 9'd5, 12'h456};
    tick();
    chk("steer_row1_filled", 64'(empty_out), 64'(2'b00));
    in_valid = 1'b0;
    tick();
    chk("steer_row0_head", 64'(packet_out[PW-1:0]), 64'({9'h015, 9'd0, 12'hABC}));
    chk("steer_row1_head", 64'(packet_out[2*PW-1:PW]), 64'({9'h1F3, 9'd0, 12'h123}));
    ren_in = 2'b11;
    tick();
    chk("steer_row1_second", 64'(packet_out[2*PW-1:PW]), 64'({9'h007, 9'd4, 12'h456}));
    chk("steer_empty_mid", 64'(empty_out), 64'(2'b01));
    ren_in = 2'b10;
    tick();
    ren_in = 2'b00;
    chk("steer_drained", 64'(empty_out), 64'(2'b11));

    // Drop of dy=-1 followed by a normal packet
    in_valid = 1'b1;
    packet_in = {9'h003, 9'h1FF, 12'h777};
    tick();
    chk("drop_not_yet", 64'(drop_error), 64'(0));
    packet_in = {9'h004, 9'd0, 12'h888};
    chk("drop_next_ready", 64'(in_ready), 64'(1));
    tick();
    chk("drop_pulse", 64'(drop_error), 64'(1));
    in_valid = 1'b0;
    tick();
    chk("drop_pulse_end", 64'(drop_error), 64'(0));
    chk("drop_no_write", 64'(empty_out), 64'(2'b10));
    chk("drop_next_head", 64'(packet_out[PW-1:0]), 64'({9'h004, 9'd0, 12'h888}));
    ren_in = 2'b01;
    tick();
    ren_in = 2'b00;

    // Full: four packets fill row0, the fifth waits in the stage
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      packet_in = {9'(i), 9'd0, 12'(16 + i)};
      tick();
    end
    in_valid = 1'b0;
    chk("full_hold", 64'(in_ready), 64'(0));
    tick();
    chk("full_still_hold", 64'(in_ready), 64'(0));
    chk("full_empty", 64'(empty_out), 64'(2'b10));
    ren_in = 2'b01;
    tick();
    ren_in = 2'b00;
    chk("full_release", 64'(in_ready), 64'(1));
    tick();
    chk("full_written", 64'(in_ready), 64'(1));
    ren_in = 2'b01;
    repeat (4) tick();
    ren_in = 2'b00;
    chk("full_drained", 64'(empty_out), 64'(2'b11));
    chk("full_model_empty", 64'(mq0.size()), 64'(0));

    // Random traffic: first both rows always reading, then random reads
    for (int c = 0; c < 500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      packet_in = rand_pkt();
      ren_in    = (c < 200) ? 2'b11 : 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
    ren_in   = 2'b11;
    repeat (12) tick();
    ren_in = 2'b00;
    chk("rand_empty", 64'(empty_out), 64'(2'b11));
    chk("rand_model_row0", 64'(mq0.size()), 64'(0));
    chk("rand_model_row1", 64'(mq1.size()), 64'(0));
    chk("rand_drops", 64'(drops_seen), 64'(drops_exp));

    // Underflow is sticky
    do_reset();
    chk("uf_clear", 64'(underflow_error), 64'(0));
    ren_in = 2'b10;
    tick();
    ren_in = 2'b00;
    chk("uf_set", 64'(underflow_error), 64'(1));
    chk("uf_no_state_change", 64'(empty_out), 64'(2'b11));
    tick();
    chk("uf_sticky", 64'(underflow_error), 64'(1));

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      packet_in = {9'h011, 9'(i % 2), 12'(32 + i)};
      tick();
    end
    #3;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_empty", 64'(empty_out), 64'(2'b11));
    chk("midrst_ready", 64'(in_ready), 64'(1));
    chk("midrst_uf", 64'(underflow_error), 64'(0));
    chk("midrst_pkt", 64'(packet_out), 64'(0));
    mq0.delete();
    mq1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    chk("midrst_no_stale", 64'(empty_out), 64'(2'b11));

`ifdef RANC_INJECTOR_STATS_EN
    do_reset();
    chk("stats_reset", 64'(row_inject_count), 64'(0));
    in_valid  = 1'b1;
    ren_in    = 2'b01;
    packet_in = {9'h001, 9'd0, 12'h5A5};
    repeat (70000) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stats_row0_sat", 64'(row_inject_count[15:0]), 64'(16'hFFFF));
    chk("stats_row1_zero", 64'(row_inject_count[31:16]), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
